// File: rtl/clk_div_bank_pkg.sv
// Shared types and helpers for the clk_div_bank divider bank.
// Config fields are carried at CFG_W bits so the slot type is independent of DIV_W (DIV_W <= CFG_W).
package clk_div_bank_pkg;

    localparam int LOCK_W = 4;
    localparam int CFG_W  = 16;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] phase;
    } ch_cfg_t;

    function automatic int ch_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // A divide of 1 cannot produce a clock, so it runs as a divide of 2.
    function automatic logic [CFG_W-1:0] eff_div(input logic [CFG_W-1:0] d);
        if (d == CFG_W'(1)) begin
            return CFG_W'(2);
        end else begin
            return d;
        end
    endfunction

    function automatic logic [CFG_W-1:0] clamp_phase(input logic [CFG_W-1:0] p,
                                                     input logic [CFG_W-1:0] d);
        if (d == CFG_W'(0)) begin
            return CFG_W'(0);
        end else if (p > d - CFG_W'(1)) begin
            return d - CFG_W'(1);
        end else begin
            return p;
        end
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, pending config slot, gate latch, lock counter, output registers.
// Optional CLK_DIV_BANK_SYNC_EN adds a sync input that realigns the counter to its phase.
module clk_div_ch
    import clk_div_bank_pkg::*;
#(
    parameter int DIV_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    cfg_we,
    input  ch_cfg_t cfg_in,
    input  logic    gate_in,
`ifdef CLK_DIV_BANK_SYNC_EN
    input  logic    sync,
`endif
    output logic    pend,
    output logic    en,
    output logic    clk_out,
    output logic    clk_q,
    output logic    tick,
    output logic    lock
);

    localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(LOCK_CNT);
    localparam logic [DIV_W-1:0]  ONE      = DIV_W'(1);

    logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d, phase_q, phase_d;
    logic              pend_q, pend_d, gate_q, gate_d, lock_q, lock_d;
    logic              clk_out_q, clk_out_d, clk_q_q, clk_q_d, tick_q, tick_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    ch_cfg_t           slot_q, slot_d;

    logic              en_s, wrap_s, apply_s, sync_s, live_s;
    logic [DIV_W-1:0]  half_s;
    logic [DIV_W:0]    qsum_s, qpos_s;

`ifdef CLK_DIV_BANK_SYNC_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    // Next-state logic: pending slot, apply at the period boundary, counter and outputs.
    always_comb begin
        en_s    = (div_q != DIV_W'(0));
        wrap_s  = en_s && (cnt_q == div_q - ONE);
        apply_s = pend_q && (!en_s || wrap_s || sync_s);
        live_s  = en_s && !gate_q;
        half_s  = div_q >> 1;
        // 90 degree tap: counter advanced by D - D/4, folded back into [0, D).
        qsum_s  = {1'b0, cnt_q} + {1'b0, div_q} - {3'b000, div_q[DIV_W-1:2]};
        if (qsum_s >= {1'b0, div_q}) begin
            qpos_s = qsum_s - {1'b0, div_q};
        end else begin
            qpos_s = qsum_s;
        end

        clk_out_d = live_s && (cnt_q < half_s);
        clk_q_d   = live_s && (qpos_s < {1'b0, half_s});
        tick_d    = live_s && (cnt_q == DIV_W'(0));

        if (!en_s || wrap_s) begin
            gate_d = gate_in;
        end else begin
            gate_d = gate_q;
        end

        if (cfg_we) begin
            pend_d = 1'b1;
            slot_d = cfg_in;
        end else if (apply_s) begin
            pend_d = 1'b0;
            slot_d = slot_q;
        end else begin
            pend_d = pend_q;
            slot_d = slot_q;
        end

        if (apply_s) begin
            div_d      = DIV_W'(eff_div(slot_q.div));
            phase_d    = DIV_W'(slot_q.phase);
            cnt_d      = DIV_W'(clamp_phase(slot_q.phase, eff_div(slot_q.div)));
            lock_cnt_d = LOCK_W'(0);
            lock_d     = 1'b0;
        end else begin
            div_d   = div_q;
            phase_d = phase_q;
            lock_d  = en_s && (lock_cnt_q == LOCK_TGT);
            if (wrap_s && (lock_cnt_q != LOCK_TGT)) begin
                lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            end else begin
                lock_cnt_d = lock_cnt_q;
            end
            if (sync_s && en_s) begin
                cnt_d = DIV_W'(clamp_phase(CFG_W'(phase_q), CFG_W'(div_q)));
            end else if (wrap_s) begin
                cnt_d = DIV_W'(0);
            end else if (en_s) begin
                cnt_d = cnt_q + ONE;
            end else begin
                cnt_d = DIV_W'(0);
            end
        end
    end

    // State registers with synchronous reset; pending configs are dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= DIV_W'(0);
            cnt_q      <= DIV_W'(0);
            phase_q    <= DIV_W'(0);
            pend_q     <= 1'b0;
            slot_q     <= '0;
            gate_q     <= 1'b0;
            lock_cnt_q <= LOCK_W'(0);
            lock_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            clk_q_q    <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            pend_q     <= pend_d;
            slot_q     <= slot_d;
            gate_q     <= gate_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
            clk_out_q  <= clk_out_d;
            clk_q_q    <= clk_q_d;
            tick_q     <= tick_d;
        end
    end

    assign pend    = pend_q;
    assign en      = en_s;
    assign clk_out = clk_out_q;
    assign clk_q   = clk_q_q;
    assign tick    = tick_q;
    assign lock    = lock_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers sharing one config port.
// Optional CLK_DIV_BANK_SYNC_EN adds a sync input that realigns all enabled channels.
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_width(NUM_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [DIV_W-1:0]            cfg_phase,
    input  logic [NUM_CH-1:0]           gate,
`ifdef CLK_DIV_BANK_SYNC_EN
    input  logic                        sync,
`endif
    output logic [NUM_CH-1:0]           clk_out,
    output logic [NUM_CH-1:0]           clk_q,
    output logic [NUM_CH-1:0]           tick,
    output logic [NUM_CH-1:0]           lock,
    output logic                        all_lock
);

    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0] pend_s, en_s, we_s;
    logic              ready_s;
    ch_cfg_t           cfg_s;

    assign cfg_s.div   = CFG_W'(cfg_div);
    assign cfg_s.phase = CFG_W'(cfg_phase);

    // Unused channel codes read as busy, so a request to them never transfers.
    generate
        if ((1 << CH_W) > NUM_CH) begin : g_pad
            logic [(1<<CH_W)-1:0] pend_ext_s;
            assign pend_ext_s = {{((1 << CH_W) - NUM_CH){1'b1}}, pend_s};
            assign ready_s    = !pend_ext_s[cfg_ch];
        end else begin : g_nopad
            assign ready_s = !pend_s[cfg_ch];
        end
    endgenerate

    assign cfg_ready = ready_s;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign we_s[i] = cfg_valid && ready_s && (cfg_ch == CH_W'(i));

            clk_div_ch #(
                .DIV_W    (DIV_W),
                .LOCK_CNT (LOCK_CNT)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .cfg_we  (we_s[i]),
                .cfg_in  (cfg_s),
                .gate_in (gate[i]),
`ifdef CLK_DIV_BANK_SYNC_EN
                .sync    (sync),
`endif
                .pend    (pend_s[i]),
                .en      (en_s[i]),
                .clk_out (clk_out[i]),
                .clk_q   (clk_q[i]),
                .tick    (tick[i]),
                .lock    (lock[i])
            );
        end
    endgenerate

    assign all_lock = (|en_s) && (&(lock | ~en_s));

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised bench for clk_div_bank against a cycle-level arithmetic model of the divider rules.
module tb_clk_div_bank;

    localparam int NUM_CH   = 4;
    localparam int DIV_W    = 8;
    localparam int LOCK_CNT = 4;

    logic              clk = 1'b0;
    logic              rst, cfg_valid, cfg_ready, all_lock;
    logic [1:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div, cfg_phase;
    logic [NUM_CH-1:0] gate, clk_out, clk_q, tick, lock;
`ifdef CLK_DIV_BANK_SYNC_EN
    logic              sync;
`endif

    always #5 clk = ~clk;

    clk_div_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .gate(gate),
`ifdef CLK_DIV_BANK_SYNC_EN
        .sync(sync),
`endif
        .clk_out(clk_out), .clk_q(clk_q), .tick(tick), .lock(lock), .all_lock(all_lock)
    );

    int checks = 0;
    int errors = 0;

    // Model state: divide, counter, pending slot, phase, latched gate, periods since apply.
    int m_div[NUM_CH], m_cnt[NUM_CH], m_pdiv[NUM_CH], m_pph[NUM_CH], m_phase[NUM_CH], m_per[NUM_CH];
    bit m_pend[NUM_CH], m_gate[NUM_CH];
    logic [NUM_CH-1:0] e_out, e_q, e_tick, e_lock;
    logic e_all;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        bit s;
        bit any_en, all_ok;
        s = 1'b0;
`ifdef CLK_DIV_BANK_SYNC_EN
        s = sync;
`endif
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = 0; m_cnt[i] = 0; m_pdiv[i] = 0; m_pph[i] = 0;
                m_phase[i] = 0; m_per[i] = 0; m_pend[i] = 0; m_gate[i] = 0;
            end
            e_out = '0; e_q = '0; e_tick = '0; e_lock = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                int d, c, nd;
                bit wrap, acc, app, live;
                d    = m_div[i];
                c    = m_cnt[i];
                wrap = (d != 0) && (c == d - 1);
                acc  = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
                live = (d != 0) && !m_gate[i];
                e_out[i]  = live && (c < d / 2);
                e_q[i]    = live && (((c + d - d / 4) % d) < d / 2);
                e_tick[i] = live && (c == 0);
                e_lock[i] = (d != 0) && (m_per[i] >= LOCK_CNT);
                app = m_pend[i] && ((d == 0) || wrap || s);
                if ((d == 0) || wrap) m_gate[i] = gate[i];
                if (app) begin
                    nd = (m_pdiv[i] == 1) ? 2 : m_pdiv[i];
                    m_div[i]   = nd;
                    m_phase[i] = m_pph[i];
                    m_cnt[i]   = (nd == 0) ? 0 : min2(m_pph[i], nd - 1);
                    m_pend[i]  = 1'b0;
                    m_per[i]   = 0;
                    e_lock[i]  = 1'b0;
                end else begin
                    if (s && d != 0) m_cnt[i] = min2(m_phase[i], d - 1);
                    else if (d != 0) m_cnt[i] = (c + 1) % d;
                    if (wrap) m_per[i]++;
                end
                if (acc) begin
                    m_pend[i] = 1'b1;
                    m_pdiv[i] = int'(cfg_div);
                    m_pph[i]  = int'(cfg_phase);
                end
            end
        end
        any_en = 1'b0;
        all_ok = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_div[i] != 0) begin
                any_en = 1'b1;
                if (!e_lock[i]) all_ok = 1'b0;
            end
        end
        e_all = any_en && all_ok;
    endtask

    // One clock: check ready on the applied inputs, advance the model, compare outputs at negedge.
    task automatic step();
        #1;
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("clk_out", 32'(clk_out), 32'(e_out));
        chk("clk_q", 32'(clk_q), 32'(e_q));
        chk("tick", 32'(tick), 32'(e_tick));
        chk("lock", 32'(lock), 32'(e_lock));
        chk("all_lock", 32'(all_lock), 32'(e_all));
    endtask

    task automatic cfg(input int ch, input int d, input int p);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = 8'(d);
        cfg_phase = 8'(p);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] h0, h1, h2;
        int cnt;
        logic prev;
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_phase = 8'd0; gate = 4'b0000;
`ifdef CLK_DIV_BANK_SYNC_EN
        sync = 1'b0;
`endif
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);

        // ch0 D=4 P=0: fixed waveform and lock after four periods.
        cfg(0, 4, 0);
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            h0 = {h0[6:0], clk_out[0]};
            h1 = {h1[6:0], clk_q[0]};
            h2 = {h2[6:0], tick[0]};
        end
        chk("ch0_out_pat", 32'(h0), 32'h000000CC);
        chk("ch0_q_pat", 32'(h1), 32'h00000066);
        chk("ch0_tick_pat", 32'(h2), 32'h00000088);
        repeat (8) step();
        chk("ch0_lock_early", 32'(lock[0]), 32'd0);
        step();
        chk("ch0_lock_rise", 32'(lock[0]), 32'd1);

        // ch1 D=6 then reconfigured to D=3 mid-period.
        cfg(1, 6, 0);
        repeat (30) step();
        chk("ch1_lock_d6", 32'(lock[1]), 32'd1);
        repeat (2) step();
        cfg(1, 3, 0);
        repeat (8) step();
        chk("ch1_lock_drop", 32'(lock[1]), 32'd0);
        repeat (16) step();
        chk("ch1_relock", 32'(lock[1]), 32'd1);

        // Stall on a busy channel while another channel is accepted.
        cfg(2, 5, 0);
        repeat (10) step();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd7; cfg_phase = 8'd0;
        step();
        cfg_div = 8'd9;
        #1;
        chk("ch2_stall", 32'(cfg_ready), 32'd0);
        cfg_ch = 2'd3; cfg_div = 8'd6;
        #1;
        chk("ch3_ready", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;

        // ch0 D=8 P=2, ch1 D=8 P=0.
        cfg(0, 8, 2);
        cfg(1, 8, 0);
        repeat (40) step();
`ifdef CLK_DIV_BANK_SYNC_EN
        cfg(1, 8, 0);
        repeat (12) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            h0 = {h0[6:0], clk_out[0]};
            h1 = {h1[6:0], clk_out[1]};
        end
        chk("sync_ch0_pat", 32'(h0), 32'h000000C3);
        chk("sync_ch1_pat", 32'(h1), 32'h000000F0);
`endif

        // Gate ch0 mid-period: outputs silent after the wrap, lock unaffected.
        repeat (2) step();
        gate[0] = 1'b1;
        repeat (9) step();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            cnt += int'(clk_out[0]) + int'(clk_q[0]) + int'(tick[0]);
        end
        chk("gate_silent", 32'(cnt), 32'd0);
        chk("gate_lock", 32'(lock[0]), 32'd1);

        // D=1 runs as D=2.
        cfg(2, 1, 0);
        repeat (10) step();
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            prev = clk_out[2];
            step();
            if (clk_out[2] != prev) cnt++;
        end
        chk("d1_toggles", 32'(cnt), 32'd4);

        // D=0 disables ch3 and drops it from all_lock.
        cfg(3, 0, 0);
        repeat (60) step();
        chk("d0_lock", 32'(lock[3]), 32'd0);
        chk("d0_out", 32'(clk_out[3]), 32'd0);
        chk("d0_all_lock", 32'(all_lock), 32'd1);
        gate = 4'b0000;

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            cfg_valid = ($urandom_range(0, 15) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 19);
            if (r < 10)       cfg_div = 8'(r);
            else if (r < 18)  cfg_div = 8'($urandom_range(10, 24));
            else if (r == 18) cfg_div = 8'd255;
            else              cfg_div = 8'd1;
            cfg_phase = 8'($urandom_range(0, 30));
            if ($urandom_range(0, 49) == 0) gate[$urandom_range(0, 3)] ^= 1'b1;
            rst = ($urandom_range(0, 699) == 0);
`ifdef CLK_DIV_BANK_SYNC_EN
            sync = ($urandom_range(0, 79) == 0);
`endif
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel fabric clock-divider bank. Generalises the fixed PLL post-dividers (GENCLK_HALF, shift-register ÷4/5/7 with 0°/90° taps) to NUM_CH independent, runtime-programmable integer dividers.
- Each channel has a programmable phase offset, a quadrature output, glitch-free reconfiguration, output gating and per-channel lock indication.
- Sits downstream of the PLL output clock. Feeds slow fabric domains as clock-enables and registered clocks.

Parameters:
- NUM_CH, 4, number of divider channels (1..16)
- DIV_W, 8, width of divide and phase fields; max divide 2^DIV_W-1
- LOCK_CNT, 4, full output periods after apply before lock asserts (1..15)

Ports:
- clk  in  1  PLL output clock; all logic on its rising edge
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept; = !pend[cfg_ch]
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_div  in  DIV_W  divide ratio D; 0 = disable channel; 1 is treated as 2
- cfg_phase  in  DIV_W  initial counter offset P
- gate  in  NUM_CH  per-channel output gate (1 = outputs held low)
- clk_out  out  NUM_CH  registered divided clock, 0°
- clk_q  out  NUM_CH  registered divided clock, 90°
- tick  out  NUM_CH  one-cycle strobe at start of each period
- lock  out  NUM_CH  channel stable
- all_lock  out  1  AND of lock over all enabled channels; 0 if none enabled

Behaviour:
- Reset:
  - All channels disabled (D=0), cnt=0, pend=0, gate latch=0.
  - clk_out, clk_q, tick, lock and all_lock are all 0. cfg_ready=1.
- Handshake:
  - Transfer occurs on cfg_valid && cfg_ready. {div, phase} are stored in the channel's pending slot and pend is set.
  - While pend is set, further requests to that channel stall. Requests to other channels proceed in the same cycle.
- Apply timing:
  - If the channel is disabled: apply on the cycle after acceptance.
  - Otherwise: apply on the cycle where cnt==D-1, i.e. at the period boundary, so no runt pulse occurs.
  - Apply loads D := cfg_div, cnt := min(P, D-1), clears pend, clears lock and resets the lock counter.
  - If the wrap and the acceptance fall in the same cycle, the new config waits for the next wrap.
- Counter:
  - Enabled channel: cnt increments and wraps at D-1 to 0.
  - Disabled channel (D=0): cnt held at 0, all outputs 0.
- Outputs (registered; 1-cycle latency from cnt):
  - H = D>>1.
  - clk_out = (cnt < H).
  - clk_q = (((cnt + D - (D>>2)) mod D) < H). This is an exact 90° only when D%4==0.
  - tick = (cnt==0).
  - Example, D=3: clk_out is high 1 cycle, low 2.
- Gate:
  - gate[i] is sampled into the gate latch only when cnt==D-1 (or at any time while disabled).
  - Latched gate forces clk_out, clk_q and tick to 0. The counter and lock keep running.
- Lock:
  - A per-channel 4-bit period counter increments on each wrap after an apply.
  - lock asserts in the cycle after the counter reaches LOCK_CNT and stays high until the next apply or reset.
  - A disable-apply (D=0) leaves lock at 0.
- Reset mid-operation: everything returns to reset values in the next cycle and pending configs are discarded.

Optional Feature:
- Macro: CLK_DIV_BANK_SYNC_EN.
- Defined:
  - Adds input sync (1 bit).
  - On sync=1, every enabled channel reloads cnt := min(P_i, D_i-1) in the next cycle, aligning all channel phases.
  - Pending configs are applied at the same instant.
  - lock is not cleared by sync alone.
- Undefined:
  - No sync port. Channels align only through individual applies.

Decomposition:
- Package clk_div_bank_pkg holds:
  - CH_W function/constant
  - LOCK_W=4
  - typedef ch_cfg_t {div[DIV_W], phase[DIV_W]}
  - function clamp_phase()
- Sub-module clk_div_ch, one per channel:
  - Contains counter, pending slot, gate latch, lock counter and output registers.
  - The top generates NUM_CH instances and builds cfg_ready, the write-enable decode and all_lock.

Test Plan:
- Reset, then cfg ch0 D=4 P=0:
  - clk_out0 = 1100 repeating and clk_q0 = 0110 repeating.
  - tick0 once every 4 cycles.
  - lock0 rises after 4 periods.
- ch1 D=6, then reconfigure to D=3 mid-period:
  - Current 6-cycle period completes intact with no runt pulse.
  - Next period is 3 cycles (high 1, low 2).
  - lock1 drops, then re-asserts after 4 periods.
- Back-to-back cfg_valid to ch2 while pend[2]=1:
  - cfg_ready=0 for ch2.
  - A concurrent request to ch3 is accepted in the same cycle.
- ch0 D=8 P=2 and ch1 D=8 P=0:
  - clk_out0 leads clk_out1 by 2 cycles.
  - With CLK_DIV_BANK_SYNC_EN defined, a sync pulse restores the 2-cycle offset after skew is injected via reconfig.
- gate0 asserted mid-high-phase:
  - Outputs stay unchanged until the wrap, then all outputs are 0.
  - lock0 remains 1.
- cfg D=1:
  - Behaves as D=2 (toggle every cycle).
- cfg D=0:
  - Outputs 0, lock 0.
  - all_lock ignores this channel.
